// File: rtl/acc_reg_file.sv
// acc_reg_file rev 1.0: 2**D x W register file plus accumulator with a one-entry forwarding write-back stage.
// Define ACC_REG_FILE_ADDR_CHECK_EN to enable out-of-range address checking (addr_err, zeroed reads, dropped writes).
`default_nettype none

module acc_reg_file #(
  parameter int W      = 8,
  parameter int D      = 3,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rAddrA,
  input  logic [ADDR_W-1:0] rAddrB,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic              sel_acc_a,
  input  logic              sel_acc_w,
  input  logic              wr_en,
  input  logic [W-1:0]      wr_data,
  input  logic              stall,
  output logic [W-1:0]      dataA,
  output logic [W-1:0]      dataB,
  output logic [W-1:0]      acc_out,
  output logic              wb_pending,
  output logic              addr_err
);

  localparam int NREG = 2 ** D;

  logic [W-1:0] regs [NREG];
  logic [W-1:0] acc;
  logic         wb_valid;
  logic         wb_to_acc;
  logic [D-1:0] wb_addr;
  logic [W-1:0] wb_data;

  logic [D-1:0] ra;
  logic [D-1:0] rb;
  logic         a_oob;
  logic         b_oob;
  logic         w_oob;
  logic         capture;
  logic         fwd_a;
  logic         fwd_b;

  assign ra = rAddrA[D-1:0];
  assign rb = rAddrB[D-1:0];

`ifdef ACC_REG_FILE_ADDR_CHECK_EN
  logic err;

  // An address only counts as out of range when this cycle actually uses it.
  assign a_oob = ~sel_acc_a & (|rAddrA[ADDR_W-1:D]);
  assign b_oob = |rAddrB[ADDR_W-1:D];
  assign w_oob = wr_en & ~sel_acc_w & (|wAddr[ADDR_W-1:D]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (a_oob || b_oob || w_oob) begin
      err <= 1'b1;
    end
  end

  assign addr_err = err;
`else
  logic unused_hi;

  assign unused_hi = ^{rAddrA[ADDR_W-1:D], rAddrB[ADDR_W-1:D], wAddr[ADDR_W-1:D]};
  assign a_oob     = 1'b0;
  assign b_oob     = 1'b0;
  assign w_oob     = 1'b0;
  assign addr_err  = 1'b0;
`endif

  assign capture = wr_en & ~stall & ~w_oob;

  // Commit of the held entry and capture of the next one happen on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      acc       <= '0;
      wb_valid  <= 1'b0;
      wb_to_acc <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      if (wb_valid) begin
        if (wb_to_acc) begin
          acc <= wb_data;
        end else begin
          regs[wb_addr] <= wb_data;
        end
      end
      wb_valid <= capture;
      if (capture) begin
        wb_to_acc <= sel_acc_w;
        wb_addr   <= wAddr[D-1:0];
        wb_data   <= wr_data;
      end
    end
  end

  assign fwd_a = wb_valid & (sel_acc_a ? wb_to_acc : (~wb_to_acc & (wb_addr == ra)));
  assign fwd_b = wb_valid & ~wb_to_acc & (wb_addr == rb);

  always_comb begin
    dataA = '0;
    if (!a_oob) begin
      if (fwd_a) begin
        dataA = wb_data;
      end else if (sel_acc_a) begin
        dataA = acc;
      end else begin
        dataA = regs[ra];
      end
    end
  end

  always_comb begin
    dataB = '0;
    if (!b_oob) begin
      dataB = fwd_b ? wb_data : regs[rb];
    end
  end

  assign acc_out    = acc;
  assign wb_pending = wb_valid;

endmodule

`default_nettype wire

// File: tb/tb_acc_reg_file.sv
// tb_acc_reg_file: directed literal checks plus randomized traffic compared every cycle against a behavioural model.
`default_nettype none

module tb_acc_reg_file;

  localparam int W      = 8;
  localparam int D      = 3;
  localparam int ADDR_W = 8;
  localparam int NREG   = 8;
`ifdef ACC_REG_FILE_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rAddrA, rAddrB, wAddr;
  logic              sel_acc_a, sel_acc_w, wr_en, stall;
  logic [W-1:0]      wr_data;
  logic [W-1:0]      dataA, dataB, acc_out;
  logic              wb_pending, addr_err;

  int checks = 0;
  int errors = 0;

  acc_reg_file #(.W(W), .D(D), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rAddrA     (rAddrA),
    .rAddrB     (rAddrB),
    .wAddr      (wAddr),
    .sel_acc_a  (sel_acc_a),
    .sel_acc_w  (sel_acc_w),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .stall      (stall),
    .dataA      (dataA),
    .dataB      (dataB),
    .acc_out    (acc_out),
    .wb_pending (wb_pending),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: committed register contents, accumulator, and the one accepted-but-uncommitted write.
  int         m_regs [NREG];
  int         m_acc;
  bit         p_valid;
  bit         p_acc;
  int         p_addr;
  int         p_data;
  bit         m_err;

  function automatic bit a_bad();
    return CHK && !sel_acc_a && (int'(rAddrA) >= NREG);
  endfunction
  function automatic bit b_bad();
    return CHK && (int'(rAddrB) >= NREG);
  endfunction
  function automatic bit w_bad();
    return CHK && wr_en && !sel_acc_w && (int'(wAddr) >= NREG);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) m_regs[i] <= 0;
      m_acc   <= 0;
      p_valid <= 1'b0;
      p_acc   <= 1'b0;
      p_addr  <= 0;
      p_data  <= 0;
      m_err   <= 1'b0;
    end else begin
      if (p_valid) begin
        if (p_acc) m_acc <= p_data;
        else       m_regs[p_addr] <= p_data;
      end
      p_valid <= wr_en && !stall && !w_bad();
      if (wr_en && !stall && !w_bad()) begin
        p_acc  <= sel_acc_w;
        p_addr <= int'(wAddr) % NREG;
        p_data <= int'(wr_data);
      end
      if (a_bad() || b_bad() || w_bad()) m_err <= 1'b1;
    end
  end

  // The newest value of a location is the pending write if it targets it, else the committed one.
  function automatic int exp_a();
    int idx;
    idx = int'(rAddrA) % NREG;
    if (a_bad()) return 0;
    if (sel_acc_a) return (p_valid && p_acc) ? p_data : m_acc;
    return (p_valid && !p_acc && p_addr == idx) ? p_data : m_regs[idx];
  endfunction

  function automatic int exp_b();
    int idx;
    idx = int'(rAddrB) % NREG;
    if (b_bad()) return 0;
    return (p_valid && !p_acc && p_addr == idx) ? p_data : m_regs[idx];
  endfunction

  always @(negedge clk) begin
    chk("cmp_dataA",      32'(dataA),      32'(exp_a()));
    chk("cmp_dataB",      32'(dataB),      32'(exp_b()));
    chk("cmp_acc_out",    32'(acc_out),    32'(m_acc));
    chk("cmp_wb_pending", 32'(wb_pending), 32'(p_valid));
    chk("cmp_addr_err",   32'(addr_err),   32'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rAddrA = '0; rAddrB = '0; wAddr = '0;
    sel_acc_a = 1'b0; sel_acc_w = 1'b0; wr_en = 1'b0; stall = 1'b0; wr_data = '0;
    #3;
    chk("reset_dataA",   32'(dataA),      32'h0);
    chk("reset_pending", 32'(wb_pending), 32'h0);
    chk("reset_err",     32'(addr_err),   32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset arriving between capture and commit discards the write.
    wr_en = 1'b1; wAddr = 8'd3; wr_data = 8'h5A;
    step();
    chk("rst_mid_pending_before", 32'(wb_pending), 32'h1);
    wr_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_pending_during", 32'(wb_pending), 32'h0);
    #1 rst_n = 1'b1;
    rAddrA = 8'd3; rAddrB = 8'd3;
    step(); #2;
    chk("rst_mid_dataA",   32'(dataA),      32'h0);
    chk("rst_mid_dataB",   32'(dataB),      32'h0);
    chk("rst_mid_acc",     32'(acc_out),    32'h0);
    chk("rst_mid_pending", 32'(wb_pending), 32'h0);

    // Basic write and forwarding.
    wAddr = 8'd2; wr_data = 8'hA5; wr_en = 1'b1; rAddrB = 8'd2;
    #2 chk("same_cycle_old", 32'(dataB), 32'h0);
    step(); wr_en = 1'b0; #2;
    chk("fwd_dataB",   32'(dataB),      32'hA5);
    chk("fwd_pending", 32'(wb_pending), 32'h1);
    step(); step(); #2;
    chk("commit_dataB",   32'(dataB),      32'hA5);
    chk("commit_pending", 32'(wb_pending), 32'h0);

    // Accumulator path.
    sel_acc_w = 1'b1; wr_data = 8'h3C; wr_en = 1'b1;
    step(); wr_en = 1'b0; sel_acc_w = 1'b0; sel_acc_a = 1'b1; #2;
    chk("acc_fwd_dataA", 32'(dataA),   32'h3C);
    chk("acc_precommit", 32'(acc_out), 32'h0);
    step(); #2;
    chk("acc_out_commit", 32'(acc_out), 32'h3C);
    sel_acc_a = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      rAddrB = 8'(i);
      step(); #2;
      chk("array_after_acc", 32'(dataB), (i == 2) ? 32'hA5 : 32'h0);
    end

    // Back-to-back writes to one register.
    wAddr = 8'd5; wr_data = 8'h11; wr_en = 1'b1;
    step(); wr_data = 8'h22;
    step(); wr_en = 1'b0; rAddrB = 8'd5; #2;
    chk("b2b_fwd", 32'(dataB), 32'h22);
    step(); step(); #2;
    chk("b2b_final", 32'(dataB), 32'h22);

    // Stall drains the held write and blocks the new one.
    wAddr = 8'd1; wr_data = 8'h77; wr_en = 1'b1; rAddrB = 8'd1;
    step(); wr_data = 8'h99; stall = 1'b1; #2;
    chk("stall_fwd",     32'(dataB),      32'h77);
    chk("stall_pending", 32'(wb_pending), 32'h1);
    step(); #2;
    chk("stall_drained", 32'(wb_pending), 32'h0);
    chk("stall_value",   32'(dataB),      32'h77);
    stall = 1'b0; wr_en = 1'b0;
    step(); #2;
    chk("stall_final", 32'(dataB), 32'h77);

    // Upper write-address bits.
    wAddr = 8'h09; wr_data = 8'hC3; wr_en = 1'b1; rAddrB = 8'd1;
    step(); wr_en = 1'b0; #2;
`ifdef ACC_REG_FILE_ADDR_CHECK_EN
    chk("oob_err",     32'(addr_err),   32'h1);
    chk("oob_pending", 32'(wb_pending), 32'h0);
    step(); #2;
    chk("oob_err_sticky", 32'(addr_err), 32'h1);
    chk("oob_reg1",       32'(dataB),    32'h77);
`else
    chk("wrap_err",     32'(addr_err),   32'h0);
    chk("wrap_pending", 32'(wb_pending), 32'h1);
    step(); #2;
    chk("wrap_reg1", 32'(dataB),    32'hC3);
    chk("wrap_err2", 32'(addr_err), 32'h0);
`endif

    // Randomized traffic, including occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      rAddrA    = 8'($urandom_range(0, 15));
      rAddrB    = 8'($urandom_range(0, 15));
      wAddr     = 8'($urandom_range(0, 15));
      sel_acc_a = ($urandom_range(0, 3) == 0);
      sel_acc_w = ($urandom_range(0, 4) == 0);
      wr_en     = ($urandom_range(0, 9) < 6);
      stall     = ($urandom_range(0, 3) == 0);
      wr_data   = 8'($urandom);
      step();
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
